// File: rtl/div_result_bcd_pkg.sv
// Shared constants and types for the divider result BCD stage.
package div_pkg;

    localparam int DIV_W_BIN = 16;
    localparam int DIV_N_DIG = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    typedef logic [4*DIV_N_DIG-1:0] bcd_t;

endpackage

// File: rtl/div_result_bcd_if.sv
// Handshake bundle between the divider, the BCD stage and the display/report consumer.
interface div_result_bcd_if;
    import div_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [DIV_W_BIN-1:0] quo_in;
    logic [DIV_W_BIN-1:0] rem_in;
    logic                 div0_in;
    logic                 out_valid;
    logic                 out_ready;
    bcd_t                 quo_bcd;
    bcd_t                 rem_bcd;
    logic                 div0_out;

    modport master (
        output in_valid, quo_in, rem_in, div0_in, out_ready,
        input  in_ready, out_valid, quo_bcd, rem_bcd, div0_out
    );

    modport slave (
        input  in_valid, quo_in, rem_in, div0_in, out_ready,
        output in_ready, out_valid, quo_bcd, rem_bcd, div0_out
    );

endinterface

// File: rtl/div_result_bcd_add3_row.sv
// Double-dabble adjust: adds 3 to every packed BCD digit that is 5 or more.
module bcd_add3_row #(
    parameter int N_DIG = 5
) (
    input  logic [4*N_DIG-1:0] i_bcd,
    output logic [4*N_DIG-1:0] o_bcd
);

    for (genvar g = 0; g < N_DIG; g++) begin : g_dig
        assign o_bcd[4*g +: 4] = (i_bcd[4*g +: 4] >= 4'd5) ? (i_bcd[4*g +: 4] + 4'd3)
                                                           : i_bcd[4*g +: 4];
    end

endmodule

// File: rtl/div_result_bcd.sv
// Captures one quotient/remainder pair and converts both to packed BCD with a
// sequential shift-add-3 engine, one bit per cycle, then holds the pair for the consumer.
module div_result_bcd
    import div_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    div_result_bcd_if.slave bus
);

    localparam int W_BIN = DIV_W_BIN;
    localparam int N_DIG = DIV_N_DIG;
    localparam int CNT_W = $clog2(W_BIN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W_BIN - 1);

    bcd_state_t       r_state;
    bcd_state_t       w_state_nxt;
    logic             w_in_ready;
    logic             w_out_valid;
    logic [CNT_W-1:0] r_cnt;
    logic [W_BIN-1:0] r_quo_bin;
    logic [W_BIN-1:0] r_rem_bin;
    bcd_t             r_quo_bcd;
    bcd_t             r_rem_bcd;
    bcd_t             w_quo_adj;
    bcd_t             w_rem_adj;
    logic             r_div0;

    bcd_add3_row #(.N_DIG(N_DIG)) u_add3_quo (.i_bcd(r_quo_bcd), .o_bcd(w_quo_adj));
    bcd_add3_row #(.N_DIG(N_DIG)) u_add3_rem (.i_bcd(r_rem_bcd), .o_bcd(w_rem_adj));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs depend on state only, so no input reaches them combinationally.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (r_cnt == CNT_LAST) w_state_nxt = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_quo_bin <= '0;
            r_rem_bin <= '0;
            r_quo_bcd <= '0;
            r_rem_bcd <= '0;
            r_div0    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_quo_bin <= bus.quo_in;
                        r_rem_bin <= bus.rem_in;
                        r_quo_bcd <= '0;
                        r_rem_bcd <= '0;
                        r_cnt     <= '0;
                        r_div0    <= bus.div0_in;
                    end
                end
                SHIFT: begin
                    {r_quo_bcd, r_quo_bin} <= {w_quo_adj, r_quo_bin} << 1;
                    {r_rem_bcd, r_rem_bin} <= {w_rem_adj, r_rem_bin} << 1;
                    r_cnt                  <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.quo_bcd   = r_quo_bcd;
    assign bus.rem_bcd   = r_rem_bcd;
    assign bus.div0_out  = r_div0;

endmodule

// File: tb/tb_div_result_bcd.sv
// Scoreboard bench for div_result_bcd: directed vectors, backpressure, reset abort, random stream.
module tb_div_result_bcd;
    import div_pkg::*;

    typedef struct {
        bcd_t q;
        bcd_t r;
        logic d0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_acc = 0;
    int   n_out = 0;
    bit   rand_rdy = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_result_bcd_if bus ();

    div_result_bcd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bcd_t ref_bcd(input int unsigned v);
        bcd_t r = '0;
        for (int i = 0; i < DIV_N_DIG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Called right after a rising edge; returns right after the accepting edge.
    task automatic send(input logic [15:0] q, input logic [15:0] r, input logic d0,
                        input bcd_t eq, input bcd_t er);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.quo_in   = q;
        bus.rem_in   = r;
        bus.div0_in  = d0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.in_ready && rst_n) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept q=%h", q);
        end else begin
            sb.push_back('{eq, er, d0});
            acc_cyc = cyc + 1;
            n_acc++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drain_timeout actual=pending%0d required=pending0", sb.size());
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        bit   prev_valid = 1'b0;
        bit   ready_chk = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                ready_chk  = 1'b0;
            end else begin
                if (ready_chk) begin
                    check("in_ready_after_out", 32'(bus.in_ready), 32'd1);
                    ready_chk = 1'b0;
                end
                if (bus.out_valid && !prev_valid)
                    check("latency", 32'(cyc - acc_cyc), 32'd16);
                if (bus.out_valid)
                    check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual=quo%h required=none", bus.quo_bcd);
                    end else begin
                        e = sb.pop_front();
                        check("quo_bcd", 32'(bus.quo_bcd), 32'(e.q));
                        check("rem_bcd", 32'(bus.rem_bcd), 32'(e.r));
                        check("div0_out", 32'(bus.div0_out), 32'(e.d0));
                    end
                    n_out++;
                    ready_chk = 1'b1;
                end
                prev_valid = bus.out_valid;
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.quo_in    = '0;
        bus.rem_in    = '0;
        bus.div0_in   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_quo_bcd", 32'(bus.quo_bcd), 32'd0);
        check("rst_rem_bcd", 32'(bus.rem_bcd), 32'd0);
        check("rst_div0_out", 32'(bus.div0_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(16'h04D2, 16'h0007, 1'b0, 20'h01234, 20'h00007);
        wait_idle();
        send(16'hFFFF, 16'h00FF, 1'b0, 20'h65535, 20'h00255);
        wait_idle();
        send(16'h0000, 16'h0000, 1'b0, 20'h00000, 20'h00000);
        send(16'hFF00, 16'h0010, 1'b1, 20'h65280, 20'h00016);
        wait_idle();

        // Backpressure with a competing request that must not be taken.
        bus.out_ready = 1'b0;
        send(16'h3039, 16'h0063, 1'b0, 20'h12345, 20'h00099);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("bp_valid_seen", 32'(seen), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.quo_in   = 16'h1111;
        bus.rem_in   = 16'h2222;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_quo_hold", 32'(bus.quo_bcd), 32'h12345);
            check("bp_rem_hold", 32'(bus.rem_bcd), 32'h00099);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_extra_valid", 32'(bus.out_valid), 32'd0);

        // Reset while cnt==7 discards the conversion.
        send(16'd500, 16'd3, 1'b1, 20'h00500, 20'h00003);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mid_quo_bcd", 32'(bus.quo_bcd), 32'd0);
        check("rst_mid_rem_bcd", 32'(bus.rem_bcd), 32'd0);
        check("rst_mid_div0_out", 32'(bus.div0_out), 32'd0);
        sb.delete();
        n_acc--;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'd42, 16'd0, 1'b0, 20'h00042, 20'h00000);
        wait_idle();

        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] q;
            logic [15:0] r;
            int          gap;
            q   = 16'($urandom);
            r   = 16'($urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send(q, r, 1'($urandom_range(0, 1)), ref_bcd(32'(q)), ref_bcd(32'(r)));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        wait_idle();
        check("stream_count", 32'(n_out), 32'(n_acc));
        check("stream_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
